apb_protocol_checker: RTL

Synthesizable, parametrised APB3 protocol checker and transfer monitor. It passively observes one APB master/slave link and tracks the transfer phase with a state machine. It flags protocol violations as one-cycle pulses, sticky flags and a first-violation code, and keeps saturating read/write/error transfer counters. It extends the interface-level assertion set with wait-state support, a timeout, stability checking and hardware-visible results, and sits beside the APB slave RAM in both RTL and emulation builds.

---
 rtl/apb_protocol_checker.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/apb_protocol_checker.sv
// Passive APB3 link monitor: tracks transfer phase and flags protocol violations.
// Also keeps saturating read/write/error completion counters.
module apb_protocol_checker #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 32,
    parameter int MAX_WAIT  = 16,
    parameter int CNT_W     = 16
) (
    input  logic              pclk,
    input  logic              preset,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr,
    input  logic              clr,
    output logic [5:0]        viol_pulse,
    output logic [5:0]        viol_sticky,
    output logic              first_vld,
    output logic [2:0]        first_code,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_cnt,
    output logic [CNT_W-1:0]  rd_cnt,
    output logic [CNT_W-1:0]  err_cnt
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
    localparam logic [WAIT_W-1:0] MAX_W   = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, SETUP, WAIT} state_t;

    state_t              state, nxt;
    logic [WAIT_W-1:0]   wait_cnt, wait_nxt, wait_inc;
    logic [ADDR_W-1:0]   cap_addr, eff_addr;
    logic                cap_write, eff_write;
    logic [DATA_W-1:0]   cap_wdata;
    logic                acc, capture, access, complete, timeout, unstable;
    logic [5:0]          pulse;

    logic unused_prdata;
    assign unused_prdata = ^prdata;

    function automatic logic [2:0] lowest(input logic [5:0] v);
        logic [2:0] code;
        code = '0;
        for (int i = 5; i >= 0; i--)
            if (v[i]) code = 3'(i);
        return code;
    endfunction

    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v,
                                              input logic inc, input logic zero);
        logic [CNT_W-1:0] base;
        base = zero ? '0 : v;
        return (inc && base != {CNT_W{1'b1}}) ? base + CNT_W'(1) : base;
    endfunction

    assign acc      = psel & penable;
    assign wait_inc = wait_cnt + WAIT_W'(1);
    // An access straight out of IDLE is judged against the values it brings with it.
    assign eff_addr  = (state == IDLE) ? paddr  : cap_addr;
    assign eff_write = (state == IDLE) ? pwrite : cap_write;
    assign unstable  = (state != IDLE) &&
                       (paddr != cap_addr || pwrite != cap_write ||
                        (cap_write && pwdata != cap_wdata));
    assign timeout   = access && !pready && wait_inc == MAX_W;

    always_ff @(posedge pclk) begin
        if (preset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            cap_addr  <= '0;
            cap_write <= 1'b0;
            cap_wdata <= '0;
        end else begin
            state    <= nxt;
            wait_cnt <= wait_nxt;
            if (capture) begin
                cap_addr  <= paddr;
                cap_write <= pwrite;
                cap_wdata <= pwdata;
            end
        end
    end

    always_comb begin
        nxt      = state;
        wait_nxt = wait_cnt;
        capture  = 1'b0;
        access   = 1'b0;
        complete = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    capture = 1'b1;
                    nxt     = SETUP;
                end else if (acc) begin
                    capture = 1'b1;
                    access  = 1'b1;
                end
            end
            SETUP, WAIT: begin
                if (acc) access = 1'b1;
                else begin
                    nxt      = IDLE;
                    wait_nxt = '0;
                end
            end
            default: nxt = IDLE;
        endcase
        if (access) begin
            if (pready) begin
                complete = 1'b1;
                nxt      = IDLE;
                wait_nxt = '0;
            end else if (timeout) begin
                nxt      = IDLE;
                wait_nxt = '0;
            end else begin
                nxt      = WAIT;
                wait_nxt = wait_inc;
            end
        end
    end

    always_comb begin
        pulse    = '0;
        pulse[0] = penable & ~psel;
        pulse[1] = (state == IDLE) && acc;
        pulse[2] = (state != IDLE) && !acc;
        pulse[3] = access && unstable;
        pulse[4] = timeout;
        pulse[5] = complete && eff_addr >= DEPTH_A && !pslverr;
    end

    // clr wipes history but the event on the same edge still lands.
    always_ff @(posedge pclk) begin
        if (preset) begin
            viol_pulse  <= '0;
            viol_sticky <= '0;
            first_vld   <= 1'b0;
            first_code  <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            err_cnt     <= '0;
        end else begin
            viol_pulse  <= pulse;
            viol_sticky <= (clr ? 6'b0 : viol_sticky) | pulse;
            if (clr || !first_vld) begin
                first_vld  <= |pulse;
                first_code <= (|pulse) ? lowest(pulse) : 3'd0;
            end
            wr_cnt  <= bump(wr_cnt,  complete &&  eff_write, clr);
            rd_cnt  <= bump(rd_cnt,  complete && !eff_write, clr);
            err_cnt <= bump(err_cnt, complete &&  pslverr,   clr);
        end
    end

    assign busy = (state != IDLE);

endmodule
